// File: rtl/lz4_seq_emitter_if.sv
// Handshake and data bundle for the LZ4 sequence emitter.
// master: the emitter itself (pops the sequence FIFO, consumes literals,
//         drives the encoded byte stream).
// slave:  the surrounding environment (FIFO, literal source, byte sink).
interface lz4_seq_emitter_if;
    logic [46:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  lit_data;
    logic        lit_valid;
    logic        lit_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;

    modport master (
        input  fifo_dout, fifo_empty, lit_data, lit_valid, out_ready,
        output fifo_rd_en, lit_ready, out_data, out_valid, frame_done
    );

    modport slave (
        output fifo_dout, fifo_empty, lit_data, lit_valid, out_ready,
        input  fifo_rd_en, lit_ready, out_data, out_valid, frame_done
    );
endinterface

// File: rtl/lz4_seq_emitter.sv
// LZ4 sequence emitter: turns one sequence descriptor (literal length,
// offset, raw match length, last flag) plus a literal byte stream into the
// LZ4 block byte format: token, literal length extension, literals, offset
// (little endian), match length extension. A last-flagged sequence stops
// after its literals and pulses frame_done once its final byte is taken.
// Optional build macro: LZ4_SEQ_EMIT_CNT_EN adds out_byte_count, a running
// count of accepted output bytes that clears after each frame_done.
module lz4_seq_emitter #(
    parameter int MIN_MATCH = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    lz4_seq_emitter_if.master    bus
`ifdef LZ4_SEQ_EMIT_CNT_EN
    ,
    output logic [31:0]          out_byte_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOKEN  = 3'd1,
        LITEXT = 3'd2,
        LITS   = 3'd3,
        OFF_LO = 3'd4,
        OFF_HI = 3'd5,
        MLEXT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [13:0] lit_len_q, lit_len_d;
    logic [15:0] off_q, off_d;
    logic [15:0] ml_q, ml_d;
    logic [15:0] ext_q, ext_d;
    logic [13:0] cnt_q, cnt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_done_q, frame_done_d;

    logic        load_ok_s;
    logic        lit_ready_s;
    logic        fifo_rd_en_s;

    // Token nibble: lengths of 15 or more saturate and spill into extension bytes.
    function automatic logic [3:0] nib_sat(input logic [15:0] len);
        if (len >= 16'd15) begin
            nib_sat = 4'hF;
        end else begin
            nib_sat = len[3:0];
        end
    endfunction

    // Next extension byte for a remaining count r: 255 while r >= 255, then r itself.
    function automatic logic [7:0] ext_byte(input logic [15:0] r);
        if (r >= 16'd255) begin
            ext_byte = 8'hFF;
        end else begin
            ext_byte = r[7:0];
        end
    endfunction

    // The output register can take a new byte when it is empty or being drained.
    assign load_ok_s    = !out_valid_q || bus.out_ready;
    assign lit_ready_s  = (state_q == LITS) && load_ok_s;
    // Gated by rstN so no pop can escape while the block is held in reset.
    assign fifo_rd_en_s = rstN && (state_q == IDLE) && !bus.fifo_empty;

    assign bus.lit_ready  = lit_ready_s;
    assign bus.fifo_rd_en = fifo_rd_en_s;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;

    // Next-state, capture and output-byte selection for the emission sequence.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        lit_len_d    = lit_len_q;
        off_d        = off_q;
        ml_d         = ml_q;
        ext_d        = ext_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_rd_en_s) begin
                    last_d    = bus.fifo_dout[46];
                    lit_len_d = bus.fifo_dout[45:32];
                    off_d     = bus.fifo_dout[31:16];
                    ml_d      = bus.fifo_dout[15:0] - 16'(MIN_MATCH);
                    cnt_d     = bus.fifo_dout[45:32];
                    ext_d     = 16'd0;
                    state_d   = TOKEN;
                end else begin
                    state_d   = IDLE;
                end
            end
            TOKEN: begin
                if (load_ok_s) begin
                    out_data_d  = {nib_sat({2'b00, lit_len_q}),
                                   (last_q ? 4'h0 : nib_sat(ml_q))};
                    out_valid_d = 1'b1;
                    if (lit_len_q >= 14'd15) begin
                        ext_d   = {2'b00, lit_len_q} - 16'd15;
                        state_d = LITEXT;
                    end else if (lit_len_q != 14'd0) begin
                        state_d = LITS;
                    end else if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = OFF_LO;
                    end
                end else begin
                    state_d = TOKEN;
                end
            end
            LITEXT: begin
                if (load_ok_s) begin
                    out_data_d  = ext_byte(ext_q);
                    out_valid_d = 1'b1;
                    if (ext_q >= 16'd255) begin
                        ext_d   = ext_q - 16'd255;
                    end else begin
                        state_d = LITS;
                    end
                end else begin
                    state_d = LITEXT;
                end
            end
            LITS: begin
                if (lit_ready_s && bus.lit_valid) begin
                    out_data_d  = bus.lit_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - 14'd1;
                    if (cnt_q == 14'd1) begin
                        state_d = last_q ? DONE : OFF_LO;
                    end else begin
                        state_d = LITS;
                    end
                end else begin
                    state_d = LITS;
                end
            end
            OFF_LO: begin
                if (load_ok_s) begin
                    out_data_d  = off_q[7:0];
                    out_valid_d = 1'b1;
                    state_d     = OFF_HI;
                end else begin
                    state_d     = OFF_LO;
                end
            end
            OFF_HI: begin
                if (load_ok_s) begin
                    out_data_d  = off_q[15:8];
                    out_valid_d = 1'b1;
                    if (ml_q >= 16'd15) begin
                        ext_d   = ml_q - 16'd15;
                        state_d = MLEXT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = OFF_HI;
                end
            end
            MLEXT: begin
                if (load_ok_s) begin
                    out_data_d  = ext_byte(ext_q);
                    out_valid_d = 1'b1;
                    if (ext_q >= 16'd255) begin
                        ext_d   = ext_q - 16'd255;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MLEXT;
                end
            end
            DONE: begin
                // The final byte of the frame is sitting in the output register.
                if (load_ok_s) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured descriptor fields and registered output stage.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            last_q       <= 1'b0;
            lit_len_q    <= 14'd0;
            off_q        <= 16'd0;
            ml_q         <= 16'd0;
            ext_q        <= 16'd0;
            cnt_q        <= 14'd0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            lit_len_q    <= lit_len_d;
            off_q        <= off_d;
            ml_q         <= ml_d;
            ext_q        <= ext_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LZ4_SEQ_EMIT_CNT_EN
    logic [31:0] out_byte_count_q, out_byte_count_d;

    // Accepted-byte counter: wraps naturally, cleared the cycle after frame_done.
    always_comb begin
        out_byte_count_d = out_byte_count_q;
        if (frame_done_q) begin
            out_byte_count_d = 32'd0;
        end else if (out_valid_q && bus.out_ready) begin
            out_byte_count_d = out_byte_count_q + 32'd1;
        end else begin
            out_byte_count_d = out_byte_count_q;
        end
    end

    // Accepted-byte counter register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_byte_count_q <= 32'd0;
        end else begin
            out_byte_count_q <= out_byte_count_d;
        end
    end

    assign out_byte_count = out_byte_count_q;
`endif

endmodule

// File: tb/tb_lz4_seq_emitter.sv
// Self-checking bench for lz4_seq_emitter: a FIFO model and literal source
// feed the block, an independent encoder model fills a scoreboard of
// expected bytes, and a monitor compares every accepted output byte.
module tb_lz4_seq_emitter;

    localparam int MIN_MATCH_TB = 4;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    lz4_seq_emitter_if bus ();

`ifdef LZ4_SEQ_EMIT_CNT_EN
    logic [31:0] out_byte_count;
`endif

    lz4_seq_emitter #(.MIN_MATCH(MIN_MATCH_TB)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .bus            (bus)
`ifdef LZ4_SEQ_EMIT_CNT_EN
        ,
        .out_byte_count (out_byte_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [46:0] fifo_q[$];
    logic [7:0]  lit_src[$];
    logic [7:0]  exp_q[$];

    bit          lit_fire    = 1'b0;
    bit          out_fire    = 1'b0;
    bit          rd_fire     = 1'b0;
    bit          ready_toggle = 1'b0;
    bit          lit_gap     = 1'b0;
    bit          stall_prev  = 1'b0;
    logic [7:0]  held        = 8'd0;
    int          fd_cnt      = 0;
    bit          gap_mon     = 1'b0;
    int          gap_run     = 0;
    int          gap_max     = 0;

    // Monitor: sample handshakes mid-cycle, score output bytes, check stalls.
    always @(negedge clk) begin
        logic [7:0] e;
        lit_fire = bus.lit_valid && bus.lit_ready;
        out_fire = bus.out_valid && bus.out_ready;
        rd_fire  = bus.fifo_rd_en;
        if (bus.fifo_rd_en === 1'b1) begin
            checks++;
            if (bus.fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL rd_en_while_empty: fifo_empty=%0b with fifo_rd_en=1", bus.fifo_empty);
            end
        end
        if (stall_prev) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0b data=%02h want valid=1 data=%02h",
                         bus.out_valid, bus.out_data, held);
            end
        end
        stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held       = bus.out_data;
        if (out_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h with empty scoreboard", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL out_byte: got %02h want %02h", bus.out_data, e);
                end
            end
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (gap_mon) begin
            if (bus.out_valid !== 1'b1) begin
                gap_run++;
                if (gap_run > gap_max) gap_max = gap_run;
            end else begin
                gap_run = 0;
            end
        end
    end

    // Driver: apply pops/transfers seen last half-cycle, then present new inputs.
    always @(posedge clk) begin
        #1;
        if (rd_fire && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (lit_fire && lit_src.size() > 0) void'(lit_src.pop_front());
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 47'd0;
        if (lit_src.size() > 0 && !(lit_gap && $urandom_range(0, 1) == 0)) begin
            bus.lit_valid = 1'b1;
            bus.lit_data  = lit_src[0];
        end else begin
            bus.lit_valid = 1'b0;
        end
        bus.out_ready = ready_toggle ? ~bus.out_ready : 1'b1;
    end

    task automatic push_ext(input int r);
        int rem;
        rem = r;
        while (rem >= 255) begin
            exp_q.push_back(8'hFF);
            rem -= 255;
        end
        exp_q.push_back(8'(rem));
    endtask

    // Reference encoder: queue FIFO word, literals and the expected byte stream.
    task automatic push_seq(input bit last, input int ll, input logic [15:0] off,
                            input logic [15:0] mraw, input logic [7:0] base);
        logic [15:0] ml;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [7:0]  b;
        ml = mraw - 16'(MIN_MATCH_TB);
        hi = (ll >= 15) ? 4'hF : 4'(ll);
        lo = last ? 4'h0 : ((ml >= 16'd15) ? 4'hF : ml[3:0]);
        exp_q.push_back({hi, lo});
        if (ll >= 15) push_ext(ll - 15);
        for (int i = 0; i < ll; i++) begin
            b = base + 8'(i * 17);
            lit_src.push_back(b);
            exp_q.push_back(b);
        end
        if (!last) begin
            exp_q.push_back(off[7:0]);
            exp_q.push_back(off[15:8]);
            if (ml >= 16'd15) push_ext(int'(ml) - 15);
        end
        fifo_q.push_back({last, 14'(ll), off, mraw});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.lit_ready !== 1'b0 ||
            bus.fifo_rd_en !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%02h lrdy=%0b rd=%0b fd=%0b want all 0",
                     bus.out_valid, bus.out_data, bus.lit_ready, bus.fifo_rd_en, bus.frame_done);
        end
        push_seq(1'b0, 3, 16'h1234, 16'd8, 8'hAA);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL reset_no_pop: got rd_en=%0b fifo_depth=%0d want 0 and 1",
                     bus.fifo_rd_en, fifo_q.size());
        end
        #1 rstN = 1'b1;
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_first_seq: %0d bytes missing want 0", exp_q.size());
        end
    endtask

    task automatic test_lengths();
        push_seq(1'b0, 15, 16'hBEEF, 16'd19, 8'h01);
        push_seq(1'b0, 0, 16'h0403, 16'd274, 8'h00);
        push_seq(1'b0, 270, 16'h0100, 16'd4, 8'h07);
        wait_drain(1000);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lengths_drain: %0d bytes missing want 0", exp_q.size());
        end
    endtask

    task automatic test_last();
        int fd0;
        fd0 = fd_cnt;
        push_seq(1'b1, 5, 16'h7777, 16'd0, 8'h50);
        wait_drain(200);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL last_drain: %0d bytes missing want 0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL frame_done_pulses: got %0d want 1", fd_cnt - fd0);
        end
        push_seq(1'b1, 0, 16'h0000, 16'd0, 8'h00);
        wait_drain(100);
        checks++;
        if (fd_cnt - fd0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL last_empty_lits: got pulses=%0d missing=%0d want 2 and 0",
                     fd_cnt - fd0, exp_q.size());
        end
    endtask

    task automatic test_stall();
        ready_toggle = 1'b1;
        lit_gap      = 1'b1;
        push_seq(1'b0, 3, 16'h1234, 16'd8, 8'hAA);
        push_seq(1'b0, 15, 16'h0A0B, 16'd19, 8'h33);
        wait_drain(1000);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d bytes missing want 0", exp_q.size());
        end
        ready_toggle = 1'b0;
        lit_gap      = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        gap_run = 0;
        gap_max = 0;
        push_seq(1'b0, 2, 16'h0010, 16'd5, 8'h10);
        push_seq(1'b0, 20, 16'h0203, 16'd40, 8'h40);
        push_seq(1'b0, 0, 16'h0001, 16'd4, 8'h00);
        push_seq(1'b0, 1, 16'hFFFF, 16'd18, 8'h99);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (bus.out_valid === 1'b1) break;
        end
        gap_mon = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        gap_mon = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d bytes missing want 0", exp_q.size());
        end
        checks++;
        if (gap_max > 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles want at most 1", gap_max);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_midreset();
        bit seen;
        seen = 1'b0;
        push_seq(1'b0, 10, 16'h5555, 16'd6, 8'h21);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (bus.lit_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_lits: lit_ready never rose want 1");
        end
        #1 rstN = 1'b0;
        exp_q.delete();
        lit_src.delete();
        fifo_q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.lit_ready !== 1'b0 ||
            bus.fifo_rd_en !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%0b data=%02h lrdy=%0b rd=%0b fd=%0b want all 0",
                     bus.out_valid, bus.out_data, bus.lit_ready, bus.fifo_rd_en, bus.frame_done);
        end
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        push_seq(1'b0, 3, 16'h1234, 16'd8, 8'hAA);
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_seq: missing=%0d fifo_depth=%0d want 0 and 0",
                     exp_q.size(), fifo_q.size());
        end
    endtask

    // Test sequence.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = 47'd0;
        bus.lit_valid  = 1'b0;
        bus.lit_data   = 8'd0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_lengths();
        test_last();
        test_stall();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
